// File: rtl/uart_wb_master.sv
// uart_wb_master: UART-byte-driven Wishbone initiator (debug bridge) issuing single 32-bit reads/writes.
module uart_wb_master #(
  parameter int unsigned BYTE_TIMEOUT = 500000,
  parameter int unsigned WB_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_frame_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        drop_pulse
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WB_REQ, RESP_STAT, RESP_DATA} state_t;
  localparam logic [31:0] BYTE_LAST = 32'(BYTE_TIMEOUT - 1);
  localparam logic [7:0]  WB_LAST = 8'(WB_TIMEOUT - 1);
  localparam logic [7:0]  ST_OK = 8'h4B;
  localparam logic [7:0]  ST_ERR = 8'h45;
  state_t      state;
  logic [1:0]  idx;
  logic [31:0] rdata;
  logic [31:0] byte_cnt;
  logic [7:0]  wait_cnt;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= 2'd0;
      rdata <= 32'h0;
      byte_cnt <= 32'h0;
      wait_cnt <= 8'h0;
      tx_data <= 8'h0;
      tx_valid <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
      drop_pulse <= 1'b0;
    end else begin
      // bytes arriving while a transaction or response is in flight are discarded
      drop_pulse <= rx_valid && (state inside {WB_REQ, RESP_STAT, RESP_DATA});
      case (state)
        IDLE: if (rx_valid) begin
          if (!rx_frame_err && (rx_data == 8'h57 || rx_data == 8'h52)) begin
            wbm_we_o <= rx_data == 8'h57;
            state <= ADDR;
            idx <= 2'd0;
            byte_cnt <= 32'h0;
          end else drop_pulse <= 1'b1;
        end
        ADDR, WDATA: if (rx_valid && rx_frame_err) begin
          drop_pulse <= 1'b1;
          state <= IDLE;
          byte_cnt <= 32'h0;
        end else if (rx_valid) begin
          byte_cnt <= 32'h0;
          idx <= idx + 2'd1;
          if (state == ADDR) wbm_adr_o <= {wbm_adr_o[23:0], rx_data};
          else wbm_dat_o <= {wbm_dat_o[23:0], rx_data};
          if (idx == 2'd3) begin
            if (state == ADDR && wbm_we_o) state <= WDATA;
            else begin
              state <= WB_REQ;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_sel_o <= 4'hF;
              wait_cnt <= 8'h0;
            end
          end
        end else if (byte_cnt == BYTE_LAST) begin
          state <= IDLE;
          byte_cnt <= 32'h0;
        end else byte_cnt <= byte_cnt + 32'd1;
        WB_REQ: if (wbm_ack_i || wait_cnt == WB_LAST) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_sel_o <= 4'h0;
          wait_cnt <= 8'h0;
          if (wbm_ack_i && !wbm_we_o) rdata <= wbm_dat_i;
          tx_data <= wbm_ack_i ? ST_OK : ST_ERR;
          tx_valid <= 1'b1;
          state <= RESP_STAT;
        end else wait_cnt <= wait_cnt + 8'd1;
        RESP_STAT: if (tx_ready) begin
          if (!wbm_we_o && tx_data == ST_OK) begin
            state <= RESP_DATA;
            idx <= 2'd0;
            tx_data <= rdata[31:24];
            rdata <= {rdata[23:0], 8'h0};
          end else begin
            tx_valid <= 1'b0;
            state <= IDLE;
          end
        end
        RESP_DATA: if (tx_ready) begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            tx_valid <= 1'b0;
            state <= IDLE;
          end else begin
            tx_data <= rdata[31:24];
            rdata <= {rdata[23:0], 8'h0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: directed-vector bench for the UART-to-Wishbone bridge.
module tb_uart_wb_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_frame_err = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;
  logic        busy, drop_pulse;
  int total = 0;
  int bad = 0;
  logic [7:0]  txq[$];
  int cyc_cycles = 0;
  int beats = 0;
  int viol = 0;
  logic [31:0] cap_adr = 32'h0, cap_dat = 32'h0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = 4'h0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [7:0]  pd = 8'h0;
  uart_wb_master #(.BYTE_TIMEOUT(100), .WB_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .busy(busy), .drop_pulse(drop_pulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (wbm_cyc_o) cyc_cycles <= cyc_cycles + 1;
    if (wbm_cyc_o && wbm_ack_i) begin
      beats <= beats + 1;
      cap_adr <= wbm_adr_o;
      cap_dat <= wbm_dat_o;
      cap_we <= wbm_we_o;
      cap_sel <= wbm_sel_o;
    end
    if (rst_n && pv && !pr && (!tx_valid || tx_data != pd)) viol <= viol + 1;
    pv <= tx_valid;
    pr <= tx_ready;
    pd <= tx_data;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    rx_data = b;
    rx_valid = 1'b1;
    rx_frame_err = err;
    tick();
    rx_valid = 1'b0;
    rx_frame_err = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
  endtask
  task automatic ack_with(input logic [31:0] d, input int delay);
    tick(delay);
    wbm_ack_i = 1'b1;
    wbm_dat_i = d;
    tick();
    wbm_ack_i = 1'b0;
  endtask
  task automatic expect_tx(input string tag, input int base, input int n, input logic [39:0] exp);
    int k = 0;
    while (txq.size() < base + n && k < 300) begin
      tick();
      k++;
    end
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    tick(4);
    check({tag, "_count"}, txq.size(), base + n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), (base + i < txq.size()) ? {24'h0, txq[base + i]} : 32'hFFFF_FFFF,
            {24'h0, exp[8*(n-1-i) +: 8]});
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int b0, c0, k, base;
    #12;
    check("rst_bus", {25'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'h0);
    check("rst_adr", wbm_adr_o, 32'h0);
    check("rst_dat", wbm_dat_o, 32'h0);
    check("rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
    check("rst_flags", {30'h0, busy, drop_pulse}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    // write 0xDEADBEEF to 0x30000004, ack on the third cyc cycle
    send(8'h57);
    send_word(32'h3000_0004);
    send(8'hDE); send(8'hAD); send(8'hBE);
    check("wr_cyc_pre", {31'h0, wbm_cyc_o}, 32'h0);
    send(8'hEF);
    check("wr_cyc_rise", {28'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, 1'b0}, 32'hE);
    check("wr_sel", {28'h0, wbm_sel_o}, 32'hF);
    ack_with(32'h0, 2);
    check("wr_cyc_fall", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    check("wr_beats", beats, 1);
    check("wr_adr", cap_adr, 32'h3000_0004);
    check("wr_dat", cap_dat, 32'hDEAD_BEEF);
    check("wr_we_sel", {27'h0, cap_we, cap_sel}, 32'h1F);
    check("wr_cyc_len", cyc_cycles, 3);
    expect_tx("wr_tx", 0, 1, 40'h4B);
    // read 0x30000000 returning 0x12345678
    base = txq.size();
    send(8'h52);
    send_word(32'h3000_0000);
    check("rd_cyc", {31'h0, wbm_cyc_o}, 32'h1);
    ack_with(32'h1234_5678, 0);
    check("rd_we", {31'h0, cap_we}, 32'h0);
    check("rd_adr", cap_adr, 32'h3000_0000);
    expect_tx("rd_tx", base, 5, 40'h4B_1234_5678);
    check("rd_txv", {31'h0, tx_valid}, 32'h0);
    // read with 7 cycles of backpressure before every response byte
    tx_ready = 1'b0;
    base = txq.size();
    send(8'h52);
    send_word(32'h0000_0040);
    ack_with(32'hA5C3_0F96, 0);
    for (int i = 0; i < 5; i++) begin
      tick(7);
      check($sformatf("bp_hold%0d", i), {31'h0, tx_valid}, 32'h1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    expect_tx("bp_tx", base, 5, 40'h4B_A5C3_0F96);
    check("bp_stable", viol, 0);
    // bus timeout, then a late ack that must be ignored
    tx_ready = 1'b0;
    c0 = cyc_cycles;
    b0 = beats;
    send(8'h52);
    send_word(32'h0000_0010);
    k = 0;
    while (wbm_cyc_o && k < 400) begin
      tick();
      k++;
    end
    check("to_cyc_len", cyc_cycles - c0, 255);
    check("to_stat", {23'h0, tx_valid, tx_data}, 32'h145);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h5555_5555;
    tick();
    wbm_ack_i = 1'b0;
    tick(2);
    check("to_late_ack", {22'h0, busy, tx_valid, tx_data}, 32'h345);
    check("to_beats", beats - b0, 0);
    base = txq.size();
    tx_ready = 1'b1;
    expect_tx("to_tx", base, 1, 40'h45);
    // frame aborts: bad opcode, inter-byte timeout, frame error
    c0 = cyc_cycles;
    base = txq.size();
    send(8'h41);
    check("bad_op", {30'h0, drop_pulse, busy}, 32'h2);
    tick();
    check("bad_op_pulse", {31'h0, drop_pulse}, 32'h0);
    send(8'h57);
    send(8'h30);
    tick(98);
    check("bto_98", {31'h0, busy}, 32'h1);
    tick();
    check("bto_99", {31'h0, busy}, 32'h1);
    tick();
    check("bto_100", {31'h0, busy}, 32'h0);
    send(8'h57);
    send(8'h30);
    send(8'h00, 1'b1);
    check("ferr", {30'h0, drop_pulse, busy}, 32'h2);
    tick(3);
    check("abort_cyc", cyc_cycles - c0, 0);
    check("abort_tx", txq.size(), base);
    // asynchronous reset while a bus cycle is open
    send(8'h52);
    send_word(32'h0000_0020);
    check("rr_cyc", {31'h0, wbm_cyc_o}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rr_async", {27'h0, wbm_cyc_o, wbm_stb_o, tx_valid, busy, |wbm_sel_o}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick();
    base = txq.size();
    send(8'h52);
    send_word(32'h0000_0044);
    ack_with(32'hCAFE_F00D, 1);
    check("rr_adr", cap_adr, 32'h0000_0044);
    expect_tx("rr_tx", base, 5, 40'h4B_CAFE_F00D);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
